// File: rtl/bus_select_decoder.sv
// rtl/bus_select_decoder.sv - queued one-hot bus source select with timed holds
//
// Purpose: requests (5-bit source code + 3-bit hold length) are queued in a
// DEPTH-entry FIFO and replayed as a one-hot Select vector.  Each code is held
// for max(len,1) cycles, and every hold is followed by one all-zero turnaround
// cycle, so two sources are never driven in adjacent cycles.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   req_valid  request present on req_code/req_len
//   req_ready  FIFO has room (count < DEPTH)
//   req_code   bus source index 0..31
//   req_len    hold length in cycles, 0 treated as 1
//   Select     registered one-hot source enable
//   busy       FSM is not IDLE
//   done       one-cycle pulse during the turnaround cycle after a hold
//   count      current FIFO occupancy

module bus_select_decoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_code,
    input  logic [2:0]               req_len,
    output logic [31:0]              Select,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [2:0]      hold;

    logic            push;
    logic            pop;
    logic [7:0]      head;
    logic [4:0]      head_code;
    logic [2:0]      head_len;
    logic [2:0]      head_hold;

    assign req_ready = (count < FULL);
    assign push      = req_valid && req_ready;
    // IDLE and GAP both take the next entry; occupancy is the pre-edge value,
    // so an entry written on this edge cannot also be read on it.
    assign pop       = (state != DRIVE) && (count != '0);
    assign busy      = (state != IDLE);

    assign head      = mem[rd_ptr];
    assign head_code = head[7:3];
    assign head_len  = head[2:0];
    assign head_hold = (head_len == 3'd0) ? 3'd0 : head_len - 3'd1;

    // Storage has no reset; entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (!clr && push) begin
            mem[wr_ptr] <= {req_code, req_len};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
            Select <= '0;
            done   <= 1'b0;
            hold   <= '0;
        end else begin
            // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            done <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pop) begin
                        Select <= 32'd1 << head_code;
                        hold   <= head_hold;
                        state  <= DRIVE;
                    end else begin
                        Select <= '0;
                        state  <= IDLE;
                    end
                end
                DRIVE: begin
                    if (hold != 3'd0) begin
                        hold <= hold - 3'd1;
                    end else begin
                        Select <= '0;
                        done   <= 1'b1;
                        state  <= GAP;
                    end
                end
                default: begin
                    Select <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_select_decoder.sv
// tb/tb_bus_select_decoder.sv - self-checking bench for bus_select_decoder
//
// Purpose: directed vector table, hand-written corner sequences and a random
// stream, all compared against a schedule model: each accepted request is
// assigned a start cycle from simple arithmetic on its accept edge and the end
// of the previous hold.
//
// Ports: none (top-level bench).

module tb_bus_select_decoder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clr;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_code;
    logic [2:0]    req_len;
    logic [31:0]   Select;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    bus_select_decoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .req_len   (req_len),
        .Select    (Select),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    int checks   = 0;
    int failures = 0;

    // Schedule model: a request accepted at edge E starts driving in cycle
    // max(E+1, previous_end+2) and holds for max(len,1) cycles; the cycle
    // right after the hold is the done/turnaround cycle.
    typedef struct {
        int code;
        int len;
        int start;
    } rec_t;

    rec_t sched[$];
    int   cyc            = 0;
    int   last_end       = -10;
    int   accepted_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (sched[i]) if (sched[i].start > cyc) n++;
        return n;
    endfunction

    function automatic void model_out(output logic [31:0] sel, output logic dn, output logic bz);
        sel = '0;
        dn  = 1'b0;
        foreach (sched[i]) begin
            if (cyc >= sched[i].start && cyc < sched[i].start + sched[i].len)
                sel = 32'd1 << sched[i].code;
            if (cyc == sched[i].start + sched[i].len)
                dn = 1'b1;
        end
        bz = (sel != '0) || dn;
    endfunction

    // One clock: drive inputs, check ready, advance model, compare outputs.
    task automatic tick(input logic c, input logic v, input int code, input int len);
        logic        exp_ready;
        logic [31:0] es;
        logic        ed;
        logic        eb;
        int          l_eff;
        int          s;
        clr       = c;
        req_valid = v;
        req_code  = code[4:0];
        req_len   = len[2:0];
        exp_ready = (model_count() < DEPTH);
        if (!c) check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
        @(posedge clk);
        cyc++;
        if (c) begin
            sched.delete();
            last_end = -10;
        end else if (v && exp_ready) begin
            l_eff = (len == 0) ? 1 : len;
            s = cyc + 1;
            if (last_end + 2 > s) s = last_end + 2;
            sched.push_back('{code, l_eff, s});
            last_end = s + l_eff - 1;
            accepted_total++;
        end
        while (sched.size() > 0 && sched[0].start + sched[0].len < cyc) sched.delete(0);
        @(negedge clk);
        model_out(es, ed, eb);
        check("select", {32'd0, Select}, {32'd0, es});
        check("done",   {63'd0, done},   {63'd0, ed});
        check("busy",   {63'd0, busy},   {63'd0, eb});
        check("count",  64'(count),      64'(model_count()));
        if (Select != '0) check("onehot", {63'd0, $onehot(Select)}, 64'd1);
    endtask

    typedef struct {
        logic        c;
        logic        v;
        int          code;
        int          len;
        logic [31:0] sel;
        logic        dn;
        logic        bz;
        int          cnt;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int waited;
        int target;
        int guard;

        vecs[0]  = '{1'b1, 1'b0,  0, 0, 32'h0000_0000, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b1,  5, 3, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[2]  = '{1'b0, 1'b0,  0, 0, 32'h0000_0020, 1'b0, 1'b1, 0};
        vecs[3]  = '{1'b0, 1'b0,  0, 0, 32'h0000_0020, 1'b0, 1'b1, 0};
        vecs[4]  = '{1'b0, 1'b0,  0, 0, 32'h0000_0020, 1'b0, 1'b1, 0};
        vecs[5]  = '{1'b0, 1'b0,  0, 0, 32'h0000_0000, 1'b1, 1'b1, 0};
        vecs[6]  = '{1'b0, 1'b0,  0, 0, 32'h0000_0000, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 1'b1,  0, 0, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b0, 1'b1, 31, 2, 32'h0000_0001, 1'b0, 1'b1, 1};
        vecs[9]  = '{1'b0, 1'b0,  0, 0, 32'h0000_0000, 1'b1, 1'b1, 1};
        vecs[10] = '{1'b0, 1'b0,  0, 0, 32'h8000_0000, 1'b0, 1'b1, 0};
        vecs[11] = '{1'b0, 1'b0,  0, 0, 32'h8000_0000, 1'b0, 1'b1, 0};
        vecs[12] = '{1'b0, 1'b0,  0, 0, 32'h0000_0000, 1'b1, 1'b1, 0};
        vecs[13] = '{1'b0, 1'b0,  0, 0, 32'h0000_0000, 1'b0, 1'b0, 0};

        clr       = 1'b1;
        req_valid = 1'b0;
        req_code  = '0;
        req_len   = '0;
        @(negedge clk);

        // Directed table: reset, single len=3 hold, then len=0 / len=2 back-to-back.
        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].c, vecs[i].v, vecs[i].code, vecs[i].len);
            check($sformatf("tbl_sel[%0d]", i),   {32'd0, Select}, {32'd0, vecs[i].sel});
            check($sformatf("tbl_done[%0d]", i),  {63'd0, done},   {63'd0, vecs[i].dn});
            check($sformatf("tbl_busy[%0d]", i),  {63'd0, busy},   {63'd0, vecs[i].bz});
            check($sformatf("tbl_count[%0d]", i), 64'(count),      64'(vecs[i].cnt));
            check($sformatf("tbl_ready[%0d]", i), {63'd0, req_ready}, 64'd1);
        end

        // Fill the FIFO behind a len=7 hold; the fifth push must be refused.
        tick(1'b0, 1'b1, 1, 7);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) check("full_ready", {63'd0, req_ready}, 64'd0);
            tick(1'b0, 1'b1, 10 + k, 3);
        end
        check("full_count", 64'(count), 64'(DEPTH));

        // Pop and refused push on the same edge while full.
        waited = 0;
        while (!done && waited < 20) begin
            tick(1'b0, 1'b0, 0, 0);
            waited++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        check("full_at_gap", 64'(count), 64'(DEPTH));
        tick(1'b0, 1'b1, 20, 2);
        check("pop_push_full_count", 64'(count), 64'(DEPTH - 1));
        check("pop_push_full_sel", {32'd0, Select}, {32'd0, 32'h0000_0400});
        for (int k = 0; k < 40; k++) tick(1'b0, 1'b0, 0, 0);
        check("drain_busy", {63'd0, busy}, 64'd0);
        check("drain_count", 64'(count), 64'd0);

        // clr during the 2nd cycle of a len=5 hold with two entries queued.
        tick(1'b1, 1'b0, 0, 0);
        tick(1'b0, 1'b1, 3, 5);
        tick(1'b0, 1'b1, 4, 2);
        tick(1'b0, 1'b1, 6, 2);
        check("mid_hold_sel", {32'd0, Select}, {32'd0, 32'h0000_0008});
        check("mid_hold_count", 64'(count), 64'd2);
        tick(1'b1, 1'b0, 0, 0);
        check("clr_sel", {32'd0, Select}, 64'd0);
        check("clr_count", 64'(count), 64'd0);
        check("clr_done", {63'd0, done}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 0, 0);
            check("post_clr_sel", {32'd0, Select}, 64'd0);
            check("post_clr_done", {63'd0, done}, 64'd0);
        end

        // Random stream of 1000 accepted requests.
        target = accepted_total + 1000;
        guard  = 0;
        while (accepted_total < target && guard < 20000) begin
            tick(1'b0, ($urandom_range(0, 99) < 45), $urandom_range(0, 31), $urandom_range(0, 7));
            guard++;
        end
        check("random_accepted", 64'(accepted_total >= target), 64'd1);
        for (int k = 0; k < 60; k++) tick(1'b0, 1'b0, 0, 0);
        check("random_drained", {63'd0, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
